// File: rtl/tl_defs.sv
// Shared traffic-light definitions: boolean macros, light encodings
// and detector FSM state encodings, used by sig_control and this block.
`ifndef TL_DEFS_SV
`define TL_DEFS_SV
`define TRUE  1'b1
`define FALSE 1'b0

package tl_defs;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RISE_QUAL = 2'd1,
        PRESENT   = 2'd2,
        FALL_QUAL = 2'd3
    } det_state_e;

endpackage
`endif

// File: rtl/bit_sync2.sv
// Two-flop synchroniser for one asynchronous input bit.
// Ports: clk_i clock, rst_i async active-high reset, d_i raw in, q_o synced out.
module bit_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cntry_car_detector.sv
// Country-road loop conditioner: sync, debounce, request hold, served count, stuck flag.
// Ports: CLOCK, CLEAR (async high), LOOP_RAW, CNTRY_SIG in; CAR_ON_CNTRY_ROAD, LOOP_FAULT, CARS_SERVED out.
module cntry_car_detector
    import tl_defs::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int STUCK_CYC    = 1000,
    parameter int CNT_W        = 8
) (
    input  logic             CLOCK,
    input  logic             CLEAR,
    input  logic             LOOP_RAW,
    input  logic [1:0]       CNTRY_SIG,
    output logic             CAR_ON_CNTRY_ROAD,
    output logic             LOOP_FAULT,
    output logic [CNT_W-1:0] CARS_SERVED
);

    localparam int QW = $clog2(DEBOUNCE_CYC + 1);
    localparam int SW = $clog2(STUCK_CYC + 1);
    localparam logic [QW-1:0] QLAST = QW'(DEBOUNCE_CYC - 1);
    localparam logic [SW-1:0] SMAX  = SW'(STUCK_CYC);

    logic             sync;
    det_state_e       state_q;
    logic [QW-1:0]    qcnt_q;
    logic [QW-1:0]    qcnt_d;
    logic [SW-1:0]    scnt_q;
    logic [SW-1:0]    scnt_d;
    logic             req_q;
    logic             fault_q;
    logic             served_q;
    logic [CNT_W-1:0] cnt_q;
    logic             depart;

    bit_sync2 u_sync (
        .clk_i (CLOCK),
        .rst_i (CLEAR),
        .d_i   (LOOP_RAW),
        .q_o   (sync)
    );

    assign qcnt_d = qcnt_q + 1'b1;
    // Stuck counter saturates so the fault stays meaningful on long holds.
    assign scnt_d = (scnt_q == SMAX) ? scnt_q : scnt_q + 1'b1;

    // With a single-sample debounce the fall is accepted straight from PRESENT.
    assign depart = !sync &&
        ((state_q == FALL_QUAL && qcnt_q == QLAST) ||
         (DEBOUNCE_CYC == 1 && state_q == PRESENT));

    always_ff @(posedge CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            state_q  <= IDLE;
            qcnt_q   <= '0;
            scnt_q   <= '0;
            req_q    <= `FALSE;
            fault_q  <= `FALSE;
            served_q <= `FALSE;
            cnt_q    <= '0;
        end else begin
            if (req_q && CNTRY_SIG == GREEN)
                served_q <= `TRUE;
            if (state_q == PRESENT) begin
                scnt_q <= scnt_d;
                if (scnt_d == SMAX)
                    fault_q <= `TRUE;
            end
            unique case (state_q)
                IDLE: begin
                    if (sync) begin
                        if (DEBOUNCE_CYC == 1) begin
                            state_q <= PRESENT;
                            req_q   <= `TRUE;
                        end else begin
                            state_q <= RISE_QUAL;
                            qcnt_q  <= QW'(1);
                        end
                    end
                end
                RISE_QUAL: begin
                    if (!sync) begin
                        state_q <= IDLE;
                        qcnt_q  <= '0;
                    end else if (qcnt_q == QLAST) begin
                        state_q <= PRESENT;
                        req_q   <= `TRUE;
                    end else begin
                        qcnt_q <= qcnt_d;
                    end
                end
                PRESENT: begin
                    if (!sync && DEBOUNCE_CYC != 1) begin
                        state_q <= FALL_QUAL;
                        qcnt_q  <= QW'(1);
                    end
                end
                FALL_QUAL: begin
                    if (sync)
                        state_q <= PRESENT;
                    else if (qcnt_q != QLAST)
                        qcnt_q <= qcnt_d;
                end
                default: state_q <= IDLE;
            endcase
            // Departure overrides the served/stuck updates above; count uses pre-edge flags.
            if (depart) begin
                state_q  <= IDLE;
                qcnt_q   <= '0;
                scnt_q   <= '0;
                req_q    <= `FALSE;
                fault_q  <= `FALSE;
                served_q <= `FALSE;
                if (served_q && !fault_q)
                    cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign CAR_ON_CNTRY_ROAD = req_q;
    assign LOOP_FAULT        = fault_q;
    assign CARS_SERVED       = cnt_q;

endmodule

// File: tb/tb_cntry_car_detector.sv
// Self-checking bench for cntry_car_detector: directed scenarios plus
// randomized loop/light stimulus against a debounce-level reference model.
module tb_cntry_car_detector;

    localparam int D = 4;
    localparam int S = 20;
    localparam int W = 8;

    logic         CLOCK = 1'b0;
    logic         CLEAR = 1'b1;
    logic         LOOP_RAW = 1'b0;
    logic [1:0]   CNTRY_SIG = 2'd0;
    logic         CAR_ON_CNTRY_ROAD;
    logic         LOOP_FAULT;
    logic [W-1:0] CARS_SERVED;

    int n_cmp = 0;
    int n_bad = 0;

    cntry_car_detector #(.DEBOUNCE_CYC(D), .STUCK_CYC(S), .CNT_W(W)) dut (
        .CLOCK             (CLOCK),
        .CLEAR             (CLEAR),
        .LOOP_RAW          (LOOP_RAW),
        .CNTRY_SIG         (CNTRY_SIG),
        .CAR_ON_CNTRY_ROAD (CAR_ON_CNTRY_ROAD),
        .LOOP_FAULT        (LOOP_FAULT),
        .CARS_SERVED       (CARS_SERVED)
    );

    always #5 CLOCK = ~CLOCK;

    // Reference model: accepted level flips after D consecutive opposite
    // synced samples; synced sample = raw as seen two edges earlier.
    bit m_p, m_srv, m_flt, h1, h2;
    int m_run, m_scnt, m_cnt;

    initial begin
        forever begin
            @(posedge CLOCK or posedge CLEAR);
            if (CLEAR) begin
                m_p = 0; m_srv = 0; m_flt = 0; h1 = 0; h2 = 0;
                m_run = 0; m_scnt = 0; m_cnt = 0;
            end else begin
                bit s, dep;
                s = h2;
                dep = m_p && !s && (m_run + 1 == D);
                if (dep) begin
                    if (m_srv && !m_flt) m_cnt = (m_cnt + 1) % (1 << W);
                    m_srv = 0; m_flt = 0; m_scnt = 0;
                end else begin
                    if (m_p && CNTRY_SIG == 2'd2) m_srv = 1;
                    if (m_p && m_run == 0) begin
                        if (m_scnt < S) m_scnt++;
                        if (m_scnt == S) m_flt = 1;
                    end
                end
                if (s != m_p) begin
                    m_run++;
                    if (m_run == D) begin m_p = !m_p; m_run = 0; end
                end else begin
                    m_run = 0;
                end
                h2 = h1;
                h1 = LOOP_RAW;
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLOCK);
            check("req_vs_model", int'(CAR_ON_CNTRY_ROAD), int'(m_p));
            check("fault_vs_model", int'(LOOP_FAULT), int'(m_flt));
            check("served_vs_model", int'(CARS_SERVED), m_cnt);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(negedge CLOCK); #1; end
    endtask

    // Counts posedges until the selected output equals want; -1 on timeout.
    task automatic wait_sig(input int sel, input bit want, input int bound,
                            output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(posedge CLOCK); #1;
            if ((sel == 0 ? CAR_ON_CNTRY_ROAD : LOOP_FAULT) == want) begin
                n = i;
                break;
            end
        end
        @(negedge CLOCK); #1;
    endtask

    task automatic served_car();
        int n;
        LOOP_RAW = 1;
        wait_sig(0, 1, 20, n);
        CNTRY_SIG = 2'd2;
        cyc(1);
        CNTRY_SIG = 2'd0;
        LOOP_RAW = 0;
        wait_sig(0, 0, 20, n);
    endtask

    initial begin
        int n;
        int seen;
        // 1: reset with loop high, then release
        LOOP_RAW = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK); #1;
            check("clear_req", int'(CAR_ON_CNTRY_ROAD), 0);
        end
        check("clear_served", int'(CARS_SERVED), 0);
        CLEAR = 0;
        wait_sig(0, 1, 20, n);
        check("rise_latency", n, 6);
        LOOP_RAW = 0;
        wait_sig(0, 0, 20, n);
        check("fall_latency_nogreen", n, 6);
        check("turned_away_no_count", int'(CARS_SERVED), 0);

        // 2: short pulse is rejected
        cyc(4);
        LOOP_RAW = 1;
        cyc(3);
        LOOP_RAW = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            seen |= int'(CAR_ON_CNTRY_ROAD);
        end
        check("short_pulse_ignored", seen, 0);

        // 3: served car, then wrap
        LOOP_RAW = 1;
        wait_sig(0, 1, 20, n);
        CNTRY_SIG = 2'd2;
        cyc(5);
        CNTRY_SIG = 2'd0;
        LOOP_RAW = 0;
        wait_sig(0, 0, 20, n);
        check("depart_latency", n, 6);
        check("served_one", int'(CARS_SERVED), 1);
        for (int i = 0; i < 254; i++) served_car();
        check("served_255", int'(CARS_SERVED), 255);
        served_car();
        check("served_wrap", int'(CARS_SERVED), 0);

        // 4: red-only car with a 2-cycle glitch
        LOOP_RAW = 1;
        wait_sig(0, 1, 20, n);
        cyc(2);
        LOOP_RAW = 0;
        cyc(2);
        LOOP_RAW = 1;
        seen = 1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            seen &= int'(CAR_ON_CNTRY_ROAD);
        end
        check("glitch_holds_req", seen, 1);
        LOOP_RAW = 0;
        wait_sig(0, 0, 20, n);
        check("red_no_count", int'(CARS_SERVED), 0);

        // 5: stuck loop with green
        LOOP_RAW = 1;
        wait_sig(0, 1, 20, n);
        CNTRY_SIG = 2'd2;
        wait_sig(1, 1, 40, n);
        check("fault_latency", n, 20);
        check("fault_req_high", int'(CAR_ON_CNTRY_ROAD), 1);
        cyc(8);
        LOOP_RAW = 0;
        CNTRY_SIG = 2'd0;
        wait_sig(0, 0, 20, n);
        check("fault_cleared", int'(LOOP_FAULT), 0);
        check("fault_no_count", int'(CARS_SERVED), 0);

        // 6: async clear mid-PRESENT with served set
        LOOP_RAW = 1;
        wait_sig(0, 1, 20, n);
        CNTRY_SIG = 2'd2;
        cyc(3);
        @(posedge CLOCK); #2;
        CLEAR = 1;
        #1;
        check("async_clear_req", int'(CAR_ON_CNTRY_ROAD), 0);
        check("async_clear_cnt", int'(CARS_SERVED), 0);
        #1;
        CLEAR = 0;
        CNTRY_SIG = 2'd0;
        wait_sig(0, 1, 20, n);
        check("requal_latency", n, 6);
        LOOP_RAW = 0;
        wait_sig(0, 0, 20, n);
        check("clear_no_count", int'(CARS_SERVED), 0);

        // Random phase against the model
        for (int k = 0; k < 300; k++) begin
            int len;
            LOOP_RAW = 1'($urandom_range(0, 1));
            len = (($urandom & 7) == 0) ? $urandom_range(20, 35)
                                        : $urandom_range(1, 10);
            for (int j = 0; j < len; j++) begin
                CNTRY_SIG = 2'($urandom);
                CLEAR = ($urandom_range(0, 199) == 0);
                cyc(1);
                CLEAR = 0;
            end
        end
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
